// File: rtl/sdes_round_sequencer.sv
// Multi-cycle S-DES encrypt/decrypt engine: IP -> FK(Ka) -> SW -> FK(Kb) -> IP^-1,
// one block in flight, a single FK datapath shared by both rounds.
module sdes_round_sequencer #(
    parameter int unsigned FK_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_decrypt,
    input  logic [0:9] in_key,
    input  logic [0:7] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [0:7] out_data,
    output logic       busy
);

    if (FK_WAIT > 7) begin : g_fk_wait_range
        $error("FK_WAIT must be in 0..7");
    end

    localparam logic [2:0] WAIT_INIT = 3'(FK_WAIT);

    // S-boxes indexed by {row, col} = {b1, b4, b2, b3}
    localparam logic [1:0] S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2,
                                       2'd3, 2'd2, 2'd1, 2'd0,
                                       2'd0, 2'd2, 2'd1, 2'd3,
                                       2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [1:0] S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                       2'd2, 2'd0, 2'd1, 2'd3,
                                       2'd3, 2'd0, 2'd1, 2'd0,
                                       2'd2, 2'd1, 2'd0, 2'd3};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        R1   = 2'd1,
        R2   = 2'd2,
        OUT  = 2'd3
    } state_e;

    function automatic logic [0:7] ip_perm(input logic [0:7] b);
        return {b[1], b[5], b[2], b[0], b[3], b[7], b[4], b[6]};
    endfunction

    function automatic logic [0:7] ip_inv_perm(input logic [0:7] b);
        return {b[3], b[0], b[2], b[4], b[6], b[1], b[7], b[5]};
    endfunction

    function automatic logic [0:9] p10_perm(input logic [0:9] k);
        return {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
    endfunction

    function automatic logic [0:7] p8_perm(input logic [0:9] k);
        return {k[5], k[2], k[6], k[3], k[7], k[4], k[9], k[8]};
    endfunction

    function automatic logic [0:3] f_box(input logic [0:3] r, input logic [0:7] sk);
        logic [0:7] x;
        logic [0:3] y;
        x = {r[3], r[0], r[1], r[2], r[1], r[2], r[3], r[0]} ^ sk;
        y = {S0[{x[0], x[3], x[1], x[2]}], S1[{x[4], x[7], x[5], x[6]}]};
        return {y[1], y[3], y[2], y[0]};
    endfunction

    function automatic logic [0:7] fk(input logic [0:7] b, input logic [0:7] sk);
        return {b[0:3] ^ f_box(b[4:7], sk), b[4:7]};
    endfunction

    state_e     state_q, state_d;
    logic [0:7] st_q, st_d;
    logic [0:9] key_q, key_d;
    logic       dec_q, dec_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic [0:7] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       busy_q, busy_d;

    logic [0:9] p10_key;
    logic [0:9] ls1_key;
    logic [0:9] ls3_key;
    logic [0:7] k1;
    logic [0:7] k2;
    logic [0:7] fk_key;
    logic [0:7] fk_out;

    // Subkeys from the latched key; round key picked by state and mode
    always_comb begin
        p10_key = p10_perm(key_q);
        ls1_key = {p10_key[1:4], p10_key[0], p10_key[6:9], p10_key[5]};
        ls3_key = {ls1_key[2:4], ls1_key[0:1], ls1_key[7:9], ls1_key[5:6]};
        k1      = p8_perm(ls1_key);
        k2      = p8_perm(ls3_key);
        fk_key  = ((state_q == R2) != dec_q) ? k2 : k1;
        fk_out  = fk(st_q, fk_key);
    end

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        key_d       = key_q;
        dec_d       = dec_q;
        wcnt_d      = wcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    st_d    = ip_perm(in_data);
                    key_d   = in_key;
                    dec_d   = in_decrypt;
                    wcnt_d  = WAIT_INIT;
                    state_d = R1;
                end
            end
            R1: begin
                if (wcnt_q != 3'd0) begin
                    wcnt_d = wcnt_q - 3'd1;
                end else begin
                    st_d    = {fk_out[4:7], fk_out[0:3]};
                    wcnt_d  = WAIT_INIT;
                    state_d = R2;
                end
            end
            R2: begin
                if (wcnt_q != 3'd0) begin
                    wcnt_d = wcnt_q - 3'd1;
                end else begin
                    out_data_d  = ip_inv_perm(fk_out);
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            st_q        <= 8'h00;
            key_q       <= 10'h000;
            dec_q       <= 1'b0;
            wcnt_q      <= 3'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            key_q       <= key_d;
            dec_q       <= dec_d;
            wcnt_q      <= wcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sdes_round_sequencer.sv
// Bench for sdes_round_sequencer: reference S-DES model feeding an expected-output queue,
// plus directed latency, backpressure and mid-block reset scenarios.
module tb_sdes_round_sequencer;

    localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    localparam int IP_T  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    localparam int IPI_T [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    localparam int EP_T  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    localparam int P4_T  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    localparam int S0_T [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    localparam int S1_T [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
    logic [0:9] in_key;
    logic [0:7] in_data, out_data;
    logic       w_in_valid, w_in_ready, w_in_decrypt, w_out_valid, w_out_ready, w_busy;
    logic [0:9] w_in_key;
    logic [0:7] w_in_data, w_out_data;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_pushed = 0;
    int         n_popped = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    sdes_round_sequencer #(.FK_WAIT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .in_key(in_key), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    sdes_round_sequencer #(.FK_WAIT(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_decrypt(w_in_decrypt), .in_key(w_in_key), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .busy(w_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int perm(input int v, input int n_in, input int tbl [10], input int n_out);
        int r = 0;
        for (int i = 0; i < n_out; i++) r = (r << 1) | ((v >> (n_in - tbl[i])) & 1);
        return r;
    endfunction

    function automatic int rotl5(input int x, input int n);
        return ((x << n) | (x >> (5 - n))) & 31;
    endfunction

    function automatic int f_model(input int r4, input int sk);
        int x, a, b, s;
        x = perm(r4, 4, EP_T, 8) ^ sk;
        a = (x >> 4) & 15;
        b = x & 15;
        s = (S0_T[((a >> 2) & 2) | (a & 1)][(a >> 1) & 3] << 2)
          |  S1_T[((b >> 2) & 2) | (b & 1)][(b >> 1) & 3];
        return perm(s, 4, P4_T, 4);
    endfunction

    function automatic int fk_model(input int v, input int sk);
        return ((((v >> 4) & 15) ^ f_model(v & 15, sk)) << 4) | (v & 15);
    endfunction

    function automatic int crypt_model(input int key, input int v, input bit dec);
        int p, l, r, k1, k2, t;
        p  = perm(key, 10, P10_T, 10);
        l  = (p >> 5) & 31;
        r  = p & 31;
        k1 = perm((rotl5(l, 1) << 5) | rotl5(r, 1), 10, P8_T, 8);
        k2 = perm((rotl5(l, 3) << 5) | rotl5(r, 3), 10, P8_T, 8);
        t  = perm(v, 8, IP_T, 8);
        t  = fk_model(t, dec ? k2 : k1);
        t  = ((t & 15) << 4) | ((t >> 4) & 15);
        t  = fk_model(t, dec ? k1 : k2);
        return perm(t, 8, IPI_T, 8);
    endfunction

    // Scoreboard: compare on every completed output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_popped++;
            if (exp_q.size() == 0) begin
                check_eq("extra_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("out_data", 32'(out_data), 32'(mon_exp));
            end
        end
    end

    // Returns #1 after the accept edge; with wait_done, garbles inputs while busy and waits for IDLE
    task automatic do_req(input int key, input int d, input bit dec, input int exp, input bit wait_done);
        int guard = 0;
        in_key     = 10'(key);
        in_data    = 8'(d);
        in_decrypt = dec;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(8'(exp));
        n_pushed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (wait_done) begin
            guard = 0;
            while (busy && guard < 100) begin
                if (!out_valid) begin
                    in_valid   = 1'($urandom);
                    in_data    = 8'($urandom);
                    in_key     = 10'($urandom);
                    in_decrypt = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
                @(posedge clk);
                #1;
                guard++;
            end
            in_valid = 1'b0;
            if (busy) check_eq("done_timeout", 32'(busy), 32'd0);
        end
    endtask

    task automatic count_to_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        int key, p, c;
        rst_n = 1'b0;
        in_valid = 1'b0; in_decrypt = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_decrypt = 1'b0; w_in_key = '0; w_in_data = '0; w_out_ready = 1'b1;
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);

        // Encrypt reference vector, latency 2
        do_req(10'b1010000010, 8'b10010111, 1'b0, 8'b00111000, 1'b0);
        count_to_valid(n);
        check_eq("enc_latency", 32'(n), 32'd2);
        check_eq("enc_data", 32'(out_data), 32'h38);
        check_eq("busy_in_out", 32'(busy), 32'd1);
        check_eq("in_ready_in_out", 32'(in_ready), 32'd0);
        @(posedge clk); #1;

        // Decrypt reference vector
        do_req(10'b1010000010, 8'b00111000, 1'b1, 8'b10010111, 1'b1);

        // FK_WAIT=3 instance: latency 8
        w_in_key = 10'b1010000010; w_in_data = 8'b10010111; w_in_decrypt = 1'b0; w_in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!w_in_ready && guard < 50) begin @(negedge clk); guard++; end
        check_eq("w_in_ready", 32'(w_in_ready), 32'd1);
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 0;
        while (!w_out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check_eq("w_latency", 32'(n), 32'd8);
        check_eq("w_data", 32'(w_out_data), 32'h38);
        @(posedge clk); #1;
        check_eq("w_handshake", 32'(w_out_valid), 32'd0);

        // Backpressure: hold out_ready low for 10 cycles in OUT
        out_ready = 1'b0;
        do_req(10'b1010000010, 8'b10010111, 1'b0, 8'b00111000, 1'b0);
        count_to_valid(n);
        check_eq("bp_reach_out", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_data", 32'(out_data), 32'h38);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_valid", 32'(out_valid), 32'd0);
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset while in R2 discards the block
        do_req(10'b1010000010, 8'b10010111, 1'b0, 8'b00111000, 1'b0);
        @(posedge clk); #1;
        check_eq("r2_busy", 32'(busy), 32'd1);
        check_eq("r2_no_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_data", 32'(out_data), 32'd0);
        exp_q.delete();
        n_pushed--;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        key = 10'h2F5;
        p   = 8'hA6;
        do_req(key, p, 1'b0, crypt_model(key, p, 1'b0), 1'b1);

        // Random roundtrips: encrypt p, then decrypt the model ciphertext back to p
        for (int i = 0; i < 150; i++) begin
            key = int'($urandom_range(1023, 0));
            p   = int'($urandom_range(255, 0));
            c   = crypt_model(key, p, 1'b0);
            do_req(key, p, 1'b0, c, 1'b1);
            do_req(key, c, 1'b1, p, 1'b1);
        end

        repeat (5) @(posedge clk);
        #1;
        check_eq("outputs_count", 32'(n_popped), 32'(n_pushed));
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
